// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register-file completer.
// Holds the transfer state encoding, the default ID word and the error-cause codes.
// Optional byte-strobe support is selected with APB_SLAVE_PSTRB_EN in the users of this package.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] APB_ID_DEFAULT = 32'hA9B0_0001;

  // Error causes, listed in decode priority order
  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_ALIGN = 3'd1;  // PADDR[1:0] != 0
  localparam logic [2:0] ERR_RANGE = 3'd2;  // address past the last register
  localparam logic [2:0] ERR_RO    = 3'd3;  // write to the read-only ID register
  localparam logic [2:0] ERR_STRB  = 3'd4;  // read carrying non-zero strobes

  function automatic logic is_err(input logic [2:0] cause);
    return cause != ERR_NONE;
  endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// Address decode for the register file: register index plus a single error flag.
// Purely combinational, zero latency; no flow control of its own.
// Strobe checking on reads is active only when APB_SLAVE_PSTRB_EN is defined.
module apb_slave_decode
  import apb_slave_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic                write,
  input  logic [DATA_W/8-1:0] strb,
  output logic [IDX_W-1:0]    idx,
  output logic                err
);

  logic [2:0]        cause;
  logic [ADDR_W-1:0] upper;
  logic              strb_bad;

  assign idx   = addr[2 +: IDX_W];
  // Anything above the index field must be zero for an in-range access
  assign upper = addr >> (2 + IDX_W);

`ifdef APB_SLAVE_PSTRB_EN
  assign strb_bad = !write && (strb != '0);
`else
  logic strb_unused;
  assign strb_unused = ^strb;
  assign strb_bad    = 1'b0;
`endif

  // First matching cause wins; any cause turns the transfer into an error response
  always_comb begin
    cause = ERR_NONE;
    if (addr[1:0] != 2'b00)
      cause = ERR_ALIGN;
    else if (upper != '0)
      cause = ERR_RANGE;
    else if (write && (idx == '0))
      cause = ERR_RO;
    else if (strb_bad)
      cause = ERR_STRB;
  end

  assign err = is_err(cause);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer fronting a small register file; reg0 is a constant ID word.
// PREADY rises in ACCESS cycle WAIT_STATES+1; all APB outputs are registered.
// Wait states are the only backpressure; APB_SLAVE_PSTRB_EN enables byte-strobed writes.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_REGS    = 8,
  parameter int                WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] ID_VALUE    = DATA_W'(APB_ID_DEFAULT)
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDR_W-1:0]            PADDR,
  input  logic [DATA_W-1:0]            PWDATA,
  input  logic [DATA_W/8-1:0]          PSTRB,
  output logic [DATA_W-1:0]            PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [NUM_REGS*DATA_W-1:0]   REGS_OUT
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_W / 8;

  state_t              state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic [ADDR_W-1:0]   dec_addr;
  logic                dec_write;
  logic [STRB_W-1:0]   dec_strb;
  logic [IDX_W-1:0]    idx;
  logic                err;
  logic [DATA_W-1:0]   rd_word;

  // In IDLE the live bus is decoded so a zero-wait transfer can respond straight
  // from SETUP; afterwards the latched copy is decoded for the response and commit.
  assign dec_addr  = (state == IDLE) ? PADDR  : addr_q;
  assign dec_write = (state == IDLE) ? PWRITE : write_q;
  assign dec_strb  = (state == IDLE) ? PSTRB  : strb_q;

  apb_slave_decode #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_decode (
    .addr  (dec_addr),
    .write (dec_write),
    .strb  (dec_strb),
    .idx   (idx),
    .err   (err)
  );

  assign rd_word = (idx == '0) ? ID_VALUE : regs_q[idx];

  // Transfer sequencing, registered response and register commit
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= (i == 0) ? ID_VALUE : '0;
    end else begin
      // Response is a one-cycle pulse; it is re-armed only on entry to DONE
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      case (state)
        IDLE: begin
          // A bare PENABLE without a preceding SETUP is ignored here
          if (PSEL && !PENABLE) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            cnt     <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state   <= DONE;
              PREADY  <= 1'b1;
              PSLVERR <= err;
              PRDATA  <= (err || PWRITE) ? '0 : rd_word;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (PSEL && PENABLE) begin
            cnt <= cnt - 4'd1;
            if (cnt <= 4'd1) begin
              state   <= DONE;
              PREADY  <= 1'b1;
              PSLVERR <= err;
              PRDATA  <= (err || write_q) ? '0 : rd_word;
            end
          end else begin
            // Master abandoned the transfer: nothing is written
            state <= IDLE;
          end
        end
        DONE: begin
          state <= IDLE;
          if (write_q && !err) begin
`ifdef APB_SLAVE_PSTRB_EN
            for (int b = 0; b < STRB_W; b++)
              if (strb_q[b])
                regs_q[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
`else
            regs_q[idx] <= wdata_q;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Parallel register image; slot 0 is the constant ID
  assign REGS_OUT[0 +: DATA_W] = ID_VALUE;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs_out
    assign REGS_OUT[i*DATA_W +: DATA_W] = regs_q[i];
  end

endmodule
